half_adder: RTL and testbench
=============================

HALF_ADDER -- requirements
Module: half_adder

Interface
Parameters:
REQ-001 WIDTH, 1, number of independent bitwise half-adder lanes.
REQ-002 CNT_W, 8, width of the carry-event counter.

Ports:
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 a  input  WIDTH  addend A, one bit per lane.
REQ-006 b  input  WIDTH  addend B, one bit per lane.
REQ-007 en  input  1  register update enable; high = capture new result.
REQ-008 cnt_clr  input  1  synchronous clear of carry_cnt.
REQ-009 s  output  WIDTH  registered sum, lane i = a[i] XOR b[i].
REQ-010 c  output  WIDTH  registered carry, lane i = a[i] AND b[i].
REQ-011 s_comb  output  WIDTH  combinational sum, a XOR b, zero latency.
REQ-012 c_comb  output  WIDTH  combinational carry, a AND b, zero latency.
REQ-013 carry_cnt  output  CNT_W  saturating count of enabled cycles with any carry lane set.

Function
REQ-014 s_comb and c_comb SHALL follow a and b combinationally, independent of clk, en and rst_n.
REQ-015 Per lane, {c,s} SHALL equal the 2-bit sum a[i]+b[i]: 00->00, 01->01, 10->01, 11->10.
REQ-016 On a rising clk edge with en=1, s and c SHALL load s_comb and c_comb (latency: 1 cycle).
REQ-017 With en=0, s and c SHALL hold their previous values.
REQ-018 On a rising edge with en=1 and |c_comb=1, carry_cnt SHALL increment by 1.
REQ-019 carry_cnt SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-020 cnt_clr=1 SHALL set carry_cnt to 0 on the next rising edge, with priority over a simultaneous increment.
REQ-021 Lanes SHALL be fully independent; no carry SHALL propagate between lanes.
REQ-022 Inputs SHALL have no X-propagation requirement beyond standard gate semantics; no assertion of illegal input combinations exists.

Reset
REQ-023 While rst_n=0, s, c and carry_cnt SHALL be 0 immediately (asynchronous), regardless of clk or en.
REQ-024 Reset asserted mid-operation SHALL discard the pending result; the first capture after release is on the first rising edge with rst_n=1 and en=1.
REQ-025 s_comb and c_comb SHALL remain functional during reset.

Verification
REQ-026 WIDTH=1, en=1: a,b stepped 00,01,10,11, each held 100 ns -> s_comb/c_comb immediately 0/0,1/0,1/0,0/1; s/c equal the same values one clk edge later.
REQ-027 en=1, a=b=1 for 3 edges then a=1,b=0 for 2 edges -> carry_cnt=3, s=1, c=0.
REQ-028 Load s=0,c=1 (a=b=1), then en=0 with a=1,b=0 for 4 edges -> s=0, c=1 held; s_comb=1, c_comb=0.
REQ-029 CNT_W=2, a=b=1, en=1 for 6 edges -> carry_cnt reads 1,2,3,3,3,3; then cnt_clr=1 with a=b=1 -> 0.
REQ-030 Mid-run, drive rst_n=0 between edges -> s, c, carry_cnt go to 0 before the next edge; resume after release per REQ-024.
REQ-031 WIDTH=4, a=4'b1100, b=4'b1010 -> s_comb=4'b0110, c_comb=4'b1000, s/c match after one enabled edge.

Source files
------------

// File: rtl/half_adder_if.sv
// Bundle of operand, control and result signals
// shared between a half_adder and its driver.
interface half_adder_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             en;
  logic             cnt_clr;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] s_comb;
  logic [WIDTH-1:0] c_comb;
  logic [CNT_W-1:0] carry_cnt;

  modport master (
    output a, b, en, cnt_clr,
    input  s, c, s_comb, c_comb, carry_cnt
  );

  modport slave (
    input  a, b, en, cnt_clr,
    output s, c, s_comb, c_comb, carry_cnt
  );
endinterface

// File: rtl/half_adder.sv
// Lane-parallel half adder with registered result
// and a saturating count of cycles that carried.
module half_adder #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input logic         clk,
  input logic         rst_n,
  half_adder_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] cry;
  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] c_q;
  logic [CNT_W-1:0] cnt_q;
  logic             any_cry;

  assign sum     = bus.a ^ bus.b;
  assign cry     = bus.a & bus.b;
  assign any_cry = |cry;

  assign bus.s_comb    = sum;
  assign bus.c_comb    = cry;
  assign bus.s         = s_q;
  assign bus.c         = c_q;
  assign bus.carry_cnt = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q <= '0;
      c_q <= '0;
    end else if (bus.en) begin
      s_q <= sum;
      c_q <= cry;
    end
  end

  // clear wins over a same-cycle increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (bus.cnt_clr) begin
      cnt_q <= '0;
    end else if (bus.en && any_cry && cnt_q != CNT_MAX) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_half_adder.sv
// Directed-vector bench for half_adder: a 1-lane
// instance and a 4-lane instance with a 2-bit counter.
module tb_half_adder;
  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  half_adder_if #(.WIDTH(1), .CNT_W(8)) ia ();
  half_adder_if #(.WIDTH(4), .CNT_W(2)) ib ();

  half_adder #(.WIDTH(1), .CNT_W(8)) u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ia)
  );

  half_adder #(.WIDTH(4), .CNT_W(2)) u_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ib)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] va [4];
  logic [1:0] vs [4];
  logic [3:0] exp_cnt [6];

  initial begin
    n_vec = 0;
    n_err = 0;
    va[0] = 2'b00; vs[0] = 2'b00;
    va[1] = 2'b01; vs[1] = 2'b01;
    va[2] = 2'b10; vs[2] = 2'b01;
    va[3] = 2'b11; vs[3] = 2'b10;
    exp_cnt[0] = 4'd1; exp_cnt[1] = 4'd2;
    exp_cnt[2] = 4'd3; exp_cnt[3] = 4'd3;
    exp_cnt[4] = 4'd3; exp_cnt[5] = 4'd3;

    rst_n = 1'b0;
    ia.a = '0; ia.b = '0;
    ia.en = 1'b1; ia.cnt_clr = 1'b0;
    ib.a = '0; ib.b = '0;
    ib.en = 1'b0; ib.cnt_clr = 1'b0;

    // reset state, even with en high across edges
    tick();
    tick();
    chk("rst_s", 32'(ia.s), 32'd0);
    chk("rst_c", 32'(ia.c), 32'd0);
    chk("rst_cnt", 32'(ia.carry_cnt), 32'd0);
    chk("rst_cnt_b", 32'(ib.carry_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // truth table: comb immediately, registered one edge later
    for (int i = 0; i < 4; i++) begin
      ia.a = va[i][1];
      ia.b = va[i][0];
      #1;
      chk("tt_s_comb", 32'(ia.s_comb), 32'(vs[i][0]));
      chk("tt_c_comb", 32'(ia.c_comb), 32'(vs[i][1]));
      tick();
      chk("tt_s", 32'(ia.s), 32'(vs[i][0]));
      chk("tt_c", 32'(ia.c), 32'(vs[i][1]));
      repeat (9) tick();
    end
    chk("tt_cnt", 32'(ia.carry_cnt), 32'd10);

    ia.cnt_clr = 1'b1;
    tick();
    ia.cnt_clr = 1'b0;
    chk("clr_cnt", 32'(ia.carry_cnt), 32'd0);

    // three carrying edges then two non-carrying
    ia.a = 1'b1; ia.b = 1'b1;
    repeat (3) tick();
    ia.a = 1'b1; ia.b = 1'b0;
    repeat (2) tick();
    chk("cnt3", 32'(ia.carry_cnt), 32'd3);
    chk("cnt3_s", 32'(ia.s), 32'd1);
    chk("cnt3_c", 32'(ia.c), 32'd0);

    // hold with en low
    ia.a = 1'b1; ia.b = 1'b1;
    tick();
    ia.en = 1'b0;
    ia.a = 1'b1; ia.b = 1'b0;
    repeat (4) tick();
    chk("hold_s", 32'(ia.s), 32'd0);
    chk("hold_c", 32'(ia.c), 32'd1);
    chk("hold_s_comb", 32'(ia.s_comb), 32'd1);
    chk("hold_c_comb", 32'(ia.c_comb), 32'd0);
    chk("hold_cnt", 32'(ia.carry_cnt), 32'd4);

    // async reset between edges
    ia.en = 1'b1;
    ia.a = 1'b1; ia.b = 1'b1;
    tick();
    chk("pre_rst_cnt", 32'(ia.carry_cnt), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_s", 32'(ia.s), 32'd0);
    chk("arst_c", 32'(ia.c), 32'd0);
    chk("arst_cnt", 32'(ia.carry_cnt), 32'd0);
    chk("arst_c_comb", 32'(ia.c_comb), 32'd1);
    chk("arst_s_comb", 32'(ia.s_comb), 32'd0);
    tick();
    chk("arst_hold_c", 32'(ia.c), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("resume_c", 32'(ia.c), 32'd1);
    chk("resume_s", 32'(ia.s), 32'd0);
    chk("resume_cnt", 32'(ia.carry_cnt), 32'd1);

    // 2-bit counter saturates at 3
    ia.en = 1'b0;
    ib.en = 1'b1;
    ib.a = 4'b0001; ib.b = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("sat_cnt", 32'(ib.carry_cnt), 32'(exp_cnt[i]));
    end
    ib.cnt_clr = 1'b1;
    tick();
    ib.cnt_clr = 1'b0;
    chk("sat_clr", 32'(ib.carry_cnt), 32'd0);

    // four independent lanes
    ib.a = 4'b1100; ib.b = 4'b1010;
    #1;
    chk("w4_s_comb", 32'(ib.s_comb), 32'h6);
    chk("w4_c_comb", 32'(ib.c_comb), 32'h8);
    tick();
    chk("w4_s", 32'(ib.s), 32'h6);
    chk("w4_c", 32'(ib.c), 32'h8);
    chk("w4_cnt", 32'(ib.carry_cnt), 32'd1);

    // no carry ripples into the next lane
    ib.a = 4'b1111; ib.b = 4'b0001;
    tick();
    chk("w4_ind_s", 32'(ib.s), 32'hE);
    chk("w4_ind_c", 32'(ib.c), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
